parity_engine: RTL and testbench
================================

# parity_engine

Parametrised parity generator/checker for DATA_W-bit words, with selectable even/odd parity. The transmit path appends a parity bit behind a registered valid/ready stage. The receive path checks incoming {data, parity} words, raises a per-word error pulse, and keeps a sticky flag and a saturating error counter. It sits between a data producer and a serial or parallel link as the standard parity stage for the 5-bit and wider datapaths.

## Interface
- DATA_W, 5, payload width in bits (≥1)
- CNT_W, 8, error counter width in bits (≥1)

- clk  in  1  clock, all logic on rising edge
- n_rst  in  1  reset, asynchronous, active-low
- odd_mode  in  1  parity mode: 0 selects even (total ones even), 1 selects odd; sampled per accepted word
- gen_valid  in  1  transmit payload valid
- gen_ready  out  1  transmit payload accepted when gen_valid & gen_ready
- gen_data  in  DATA_W  transmit payload
- out_valid  out  1  encoded word valid
- out_ready  in  1  downstream ready
- out_word  out  DATA_W+1  {gen_data, parity}, parity in bit 0
- chk_valid  in  1  receive word valid (no backpressure)
- chk_word  in  DATA_W+1  received {data, parity}, parity in bit 0
- chk_done  out  1  one-cycle pulse: check result valid
- chk_err  out  1  parity mismatch for the word reported by chk_done; meaningful only while chk_done=1
- chk_data  out  DATA_W  payload of the checked word
- err_clr  in  1  synchronous clear of err_sticky and err_cnt
- err_sticky  out  1  set on any mismatch, held until err_clr
- err_cnt  out  CNT_W  count of mismatches, saturating at all-ones

## Operation
- Parity: p = ^data ^ odd_mode. Even mode with data 5'b10110 gives p=1. Odd mode with the same data gives p=0.
- Generate path: single output register.
  - gen_ready = !out_valid | out_ready.
  - On acceptance, out_word <= {gen_data, p} using odd_mode in that cycle, and out_valid <= 1.
  - out_valid clears when out_ready=1 and no new word is accepted.
  - out_word holds stable while out_valid=1 and out_ready=0.
- Check path, applied when chk_valid=1:
  - Compute the expected parity from chk_word[DATA_W:1] and odd_mode.
  - Mismatch = expected != chk_word[0].
  - Next cycle: chk_done=1, chk_err=mismatch, chk_data=payload.
- Error state:
  - A mismatch sets err_sticky.
  - A mismatch increments err_cnt unless err_cnt is already all-ones (saturate, no wrap).
  - err_clr=1 zeroes both. If err_clr coincides with a registered mismatch, clear wins: the count stays 0, the sticky flag stays 0, and chk_err still pulses.
- Changing odd_mode affects only words accepted or checked on or after the change. It does not affect words already in the output register.
- Both paths operate independently and may be active in the same cycle.

## Timing
- Reset values: out_valid=0, out_word=0, chk_done=0, chk_err=0, chk_data=0, err_sticky=0, err_cnt=0. gen_ready=1 after reset.
- Generate latency: accepted in cycle N, out_valid/out_word visible in cycle N+1.
- Generate throughput: one word per cycle while out_ready=1. The path sustains back-to-back transfers, including accept and drain in the same cycle.
- Check latency: chk_valid in cycle N gives chk_done/chk_err/chk_data in cycle N+1. Back-to-back checks produce back-to-back pulses.
- err_sticky and err_cnt update in the same cycle as the corresponding chk_err. Relative to chk_valid, that is one cycle later.
- Reset asserted mid-transfer:
  - An un-drained out_word is discarded.
  - A pending check result is dropped.
  - Counters zero immediately (asynchronous).
- Deasserting n_rst takes effect on the next rising clk.

## Configuration
- PARITY_ERR_CNT_EN defined: err_sticky and err_cnt registers and err_clr handling are implemented as above.
- PARITY_ERR_CNT_EN undefined:
  - err_sticky ties to 0 and err_cnt ties to 0.
  - err_clr is ignored.
  - chk_done, chk_err and chk_data behave identically.

## Structure
- Shared package parity_pkg holds:
  - PAR_EVEN = 1'b0 and PAR_ODD = 1'b1
  - the parity function (XOR-reduce of data, XORed with mode)
- Sub-module parity_calc: combinational, parameter DATA_W, inputs data and odd_mode, output p. It is instantiated twice, once per path.

## Test plan
- Reset, then even mode, gen_data=5'b10110 with out_ready=1 → next cycle out_valid=1, out_word=6'b101101. Repeat in odd mode → out_word=6'b101100.
- Backpressure: out_ready=0, two words offered → first captured, gen_ready=0 and out_word stable. Raise out_ready → second word follows on the next cycle, none lost or duplicated.
- Even mode, chk_word=6'b101101 → chk_done=1, chk_err=0, chk_data=5'b10110. chk_word=6'b101100 → chk_err=1, err_sticky=1, err_cnt=1.
- CNT_W=2, five consecutive bad words → err_cnt goes 1,2,3,3,3. err_clr → 0.
- err_clr in the same cycle as a registered mismatch → chk_err=1, err_cnt=0, err_sticky=0.
- n_rst pulsed while out_valid=1 and err_cnt=2 → all outputs at reset values immediately. With PARITY_ERR_CNT_EN undefined, err_cnt stays 0 after bad words.

Source files
------------

// File: rtl/parity_pkg.sv
// Shared definitions for the parity stage: mode encodings, the check-result
// record and the parity helper used by every parity_calc instance.
package parity_pkg;

   // Parity mode encodings as seen on odd_mode.
   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   // Widest payload the helper accepts; narrower payloads are zero-extended,
   // which leaves the XOR-reduce unchanged.
   localparam int PAR_MAX_W = 256;

   // Registered check result reported alongside chk_data.
   typedef struct packed {
      logic done;
      logic err;
   } chk_status_t;

   // Parity bit that makes the total ones count even (mode 0) or odd (mode 1).
   function automatic logic parity_of(input logic [PAR_MAX_W-1:0] data,
                                      input logic                 odd_mode);
      return (^data) ^ odd_mode;
   endfunction

endpackage

// File: rtl/parity_calc.sv
// Combinational parity bit for a DATA_W-bit payload under the selected mode.
module parity_calc
   import parity_pkg::*;
#(
   parameter int DATA_W = 5
) (
   input  logic [DATA_W-1:0] data,
   input  logic              odd_mode,
   output logic              p
);

   logic [PAR_MAX_W-1:0] data_ext_s;

   // Zero-extend the payload and apply the shared parity helper.
   always_comb begin
      data_ext_s             = {PAR_MAX_W{1'b0}};
      data_ext_s[DATA_W-1:0] = data;
      p                      = parity_of(data_ext_s, odd_mode);
   end

endmodule

// File: rtl/parity_engine.sv
// Parity generator/checker for DATA_W-bit words with even/odd selection.
// Transmit: one-deep valid/ready output register appending parity in bit 0.
// Receive: one-cycle check pulse with payload and mismatch flag.
// Build option PARITY_ERR_CNT_EN: when defined, a sticky error flag and a
// saturating CNT_W-bit mismatch counter (cleared by err_clr) are implemented;
// otherwise both outputs are tied low and err_clr is ignored.
module parity_engine
   import parity_pkg::*;
#(
   parameter int DATA_W = 5,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              odd_mode,
   // transmit side
   input  logic              gen_valid,
   output logic              gen_ready,
   input  logic [DATA_W-1:0] gen_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W:0]   out_word,
   // receive side
   input  logic              chk_valid,
   input  logic [DATA_W:0]   chk_word,
   output logic              chk_done,
   output logic              chk_err,
   output logic [DATA_W-1:0] chk_data,
   // error bookkeeping
   input  logic              err_clr,
   output logic              err_sticky,
   output logic [CNT_W-1:0]  err_cnt
);

   // ------------------------------------------------------------------
   // Transmit path
   // ------------------------------------------------------------------
   logic              gen_p_s;
   logic              gen_accept_s;
   logic              out_valid_r;
   logic [DATA_W:0]   out_word_r;

   parity_calc #(
      .DATA_W   (DATA_W)
   ) u_gen_calc (
      .data     (gen_data),
      .odd_mode (odd_mode),
      .p        (gen_p_s)
   );

   // The output register can take a new word when empty or draining this cycle.
   assign gen_ready    = !out_valid_r || out_ready;
   assign gen_accept_s = gen_valid && gen_ready;

   // Output register: capture on accept, empty on drain, otherwise hold stable.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         out_valid_r <= 1'b0;
         out_word_r  <= {(DATA_W+1){1'b0}};
      end else if (gen_accept_s) begin
         out_valid_r <= 1'b1;
         out_word_r  <= {gen_data, gen_p_s};
      end else if (out_ready) begin
         out_valid_r <= 1'b0;
         out_word_r  <= out_word_r;
      end else begin
         out_valid_r <= out_valid_r;
         out_word_r  <= out_word_r;
      end
   end

   assign out_valid = out_valid_r;
   assign out_word  = out_word_r;

   // ------------------------------------------------------------------
   // Receive path
   // ------------------------------------------------------------------
   logic              chk_p_s;
   logic              mismatch_s;
   logic              chk_bad_s;
   chk_status_t       chk_status_r;
   logic [DATA_W-1:0] chk_data_r;

   parity_calc #(
      .DATA_W   (DATA_W)
   ) u_chk_calc (
      .data     (chk_word[DATA_W:1]),
      .odd_mode (odd_mode),
      .p        (chk_p_s)
   );

   assign mismatch_s = (chk_p_s != chk_word[0]);
   assign chk_bad_s  = chk_valid && mismatch_s;

   // Check result register: one-cycle pulse per received word, payload held.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         chk_status_r <= '{done: 1'b0, err: 1'b0};
         chk_data_r   <= {DATA_W{1'b0}};
      end else if (chk_valid) begin
         chk_status_r <= '{done: 1'b1, err: mismatch_s};
         chk_data_r   <= chk_word[DATA_W:1];
      end else begin
         chk_status_r <= '{done: 1'b0, err: 1'b0};
         chk_data_r   <= chk_data_r;
      end
   end

   assign chk_done = chk_status_r.done;
   assign chk_err  = chk_status_r.err;
   assign chk_data = chk_data_r;

   // ------------------------------------------------------------------
   // Error bookkeeping
   // ------------------------------------------------------------------
`ifdef PARITY_ERR_CNT_EN
   logic              err_sticky_r;
   logic              err_sticky_nxt_s;
   logic [CNT_W-1:0]  err_cnt_r;
   logic [CNT_W-1:0]  err_cnt_nxt_s;

   // Next error state: clear has priority, counter saturates at all-ones.
   always_comb begin
      err_sticky_nxt_s = err_sticky_r;
      err_cnt_nxt_s    = err_cnt_r;
      if (err_clr) begin
         err_sticky_nxt_s = 1'b0;
         err_cnt_nxt_s    = {CNT_W{1'b0}};
      end else if (chk_bad_s) begin
         err_sticky_nxt_s = 1'b1;
         if (err_cnt_r != {CNT_W{1'b1}}) begin
            err_cnt_nxt_s = err_cnt_r + CNT_W'(1'b1);
         end else begin
            err_cnt_nxt_s = err_cnt_r;
         end
      end else begin
         err_sticky_nxt_s = err_sticky_r;
         err_cnt_nxt_s    = err_cnt_r;
      end
   end

   // Error state registers, updated on the same edge as the check result.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         err_sticky_r <= 1'b0;
         err_cnt_r    <= {CNT_W{1'b0}};
      end else begin
         err_sticky_r <= err_sticky_nxt_s;
         err_cnt_r    <= err_cnt_nxt_s;
      end
   end

   assign err_sticky = err_sticky_r;
   assign err_cnt    = err_cnt_r;
`else
   logic unused_err_s;

   // Bookkeeping is not built: inputs only feed a sink, outputs read zero.
   assign unused_err_s = err_clr ^ chk_bad_s;
   assign err_sticky   = 1'b0;
   assign err_cnt      = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_parity_engine.sv
// Self-checking bench for parity_engine: directed scenarios followed by
// random traffic, compared against a queue/count-based reference model.
module tb_parity_engine;

   localparam int DATA_W = 5;
   localparam int CNT_W  = 2;
`ifdef PARITY_ERR_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic              clk;
   logic              n_rst;
   logic              odd_mode;
   logic              gen_valid;
   logic              gen_ready;
   logic [DATA_W-1:0] gen_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W:0]   out_word;
   logic              chk_valid;
   logic [DATA_W:0]   chk_word;
   logic              chk_done;
   logic              chk_err;
   logic [DATA_W-1:0] chk_data;
   logic              err_clr;
   logic              err_sticky;
   logic [CNT_W-1:0]  err_cnt;

   parity_engine #(
      .DATA_W     (DATA_W),
      .CNT_W      (CNT_W)
   ) dut (
      .clk        (clk),
      .n_rst      (n_rst),
      .odd_mode   (odd_mode),
      .gen_valid  (gen_valid),
      .gen_ready  (gen_ready),
      .gen_data   (gen_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_word   (out_word),
      .chk_valid  (chk_valid),
      .chk_word   (chk_word),
      .chk_done   (chk_done),
      .chk_err    (chk_err),
      .chk_data   (chk_data),
      .err_clr    (err_clr),
      .err_sticky (err_sticky),
      .err_cnt    (err_cnt)
   );

   always #5 clk = ~clk;

   int checks;
   int errors;

   // reference model state
   logic [DATA_W:0]   m_q[$];
   int                m_cnt;
   bit                m_sticky;
   bit                m_done;
   bit                m_err;
   logic [DATA_W-1:0] m_data;

   // Parity bit from the ones count: make the total even (mode 0) or odd (mode 1).
   function automatic logic ref_par(input logic [DATA_W-1:0] d, input logic odd);
      int ones;
      ones = $countones(d);
      if (ones % 2 == 1) return !odd;
      else               return odd;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      gen_valid = 1'b0;
      chk_valid = 1'b0;
      err_clr   = 1'b0;
   endtask

   // One clock: inputs already driven; predict, advance, compare.
   task automatic cycle();
      bit drain;
      bit acc;
      bit bad;
      #1;
      check("gen_ready", gen_ready, (m_q.size() == 0) || out_ready);
      drain = (m_q.size() != 0) && out_ready;
      acc   = gen_valid && ((m_q.size() == 0) || out_ready);
      if (drain) void'(m_q.pop_front());
      if (acc) m_q.push_back({gen_data, ref_par(gen_data, odd_mode)});
      bad    = chk_valid && (ref_par(chk_word[DATA_W:1], odd_mode) != chk_word[0]);
      m_done = chk_valid;
      m_err  = bad;
      if (chk_valid) m_data = chk_word[DATA_W:1];
      if (CNT_EN) begin
         if (err_clr) begin
            m_cnt    = 0;
            m_sticky = 1'b0;
         end else if (bad) begin
            m_sticky = 1'b1;
            if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
         end
      end
      @(posedge clk);
      #1;
      check("out_valid", out_valid, m_q.size() != 0);
      if (m_q.size() != 0) check("out_word", out_word, m_q[0]);
      check("chk_done", chk_done, m_done);
      if (m_done) begin
         check("chk_err", chk_err, m_err);
         check("chk_data", chk_data, m_data);
      end
      check("err_sticky", err_sticky, m_sticky);
      check("err_cnt", err_cnt, m_cnt);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_out_valid"}, out_valid, 1'b0);
      check({tag, "_out_word"}, out_word, 6'b000000);
      check({tag, "_chk_done"}, chk_done, 1'b0);
      check({tag, "_chk_err"}, chk_err, 1'b0);
      check({tag, "_chk_data"}, chk_data, 5'b00000);
      check({tag, "_err_sticky"}, err_sticky, 1'b0);
      check({tag, "_err_cnt"}, err_cnt, 2'b00);
      check({tag, "_gen_ready"}, gen_ready, 1'b1);
   endtask

   task automatic model_reset();
      m_q.delete();
      m_cnt    = 0;
      m_sticky = 1'b0;
      m_done   = 1'b0;
      m_err    = 1'b0;
      m_data   = 5'b00000;
   endtask

   int exp_sat[5];

   initial begin
      checks    = 0;
      errors    = 0;
      clk       = 1'b0;
      n_rst     = 1'b0;
      odd_mode  = 1'b0;
      gen_data  = 5'b00000;
      out_ready = 1'b1;
      chk_word  = 6'b000000;
      idle();
      model_reset();

      // reset state
      #12;
      check_reset_values("rst");
      @(negedge clk);
      n_rst = 1'b1;
      @(posedge clk);
      #1;

      // even then odd encoding of 10110
      odd_mode = 1'b0; gen_valid = 1'b1; gen_data = 5'b10110; out_ready = 1'b1;
      cycle();
      check("tp_even_word", out_word, 6'b101101);
      odd_mode = 1'b1;
      cycle();
      check("tp_odd_word", out_word, 6'b101100);
      idle();
      cycle();

      // backpressure: two words offered while blocked
      odd_mode = 1'b0; out_ready = 1'b0; gen_valid = 1'b1; gen_data = 5'b00011;
      cycle();
      gen_data = 5'b11100;
      cycle();
      check("bp_hold_ready", gen_ready, 1'b0);
      check("bp_hold_word", out_word, 6'b000110);
      cycle();
      out_ready = 1'b1;
      cycle();
      check("bp_second_word", out_word, 6'b111001);
      idle();
      cycle();
      check("bp_drained", out_valid, 1'b0);

      // check path, even mode
      chk_valid = 1'b1; chk_word = 6'b101101;
      cycle();
      check("tp_chk_ok_err", chk_err, 1'b0);
      check("tp_chk_ok_data", chk_data, 5'b10110);
      chk_word = 6'b101100;
      cycle();
      check("tp_chk_bad_err", chk_err, 1'b1);
      check("tp_chk_bad_cnt", err_cnt, CNT_EN ? 2'd1 : 2'd0);
      check("tp_chk_bad_sticky", err_sticky, CNT_EN);

      // saturation over five bad words after a clear
      idle(); err_clr = 1'b1;
      cycle();
      exp_sat = '{1, 2, 3, 3, 3};
      err_clr = 1'b0; chk_valid = 1'b1; chk_word = 6'b101100;
      for (int i = 0; i < 5; i++) begin
         cycle();
         check("sat_cnt", err_cnt, CNT_EN ? exp_sat[i] : 0);
      end
      idle(); err_clr = 1'b1;
      cycle();
      check("sat_clr", err_cnt, 2'd0);

      // clear coinciding with a mismatch
      err_clr = 1'b0; chk_valid = 1'b1; chk_word = 6'b000001;
      cycle();
      err_clr = 1'b1;
      cycle();
      check("clr_win_err", chk_err, 1'b1);
      check("clr_win_cnt", err_cnt, 2'd0);
      check("clr_win_sticky", err_sticky, 1'b0);

      // reset mid-transfer with a full output register and count 2
      idle(); out_ready = 1'b0; gen_valid = 1'b1; gen_data = 5'b01010;
      chk_valid = 1'b1; chk_word = 6'b000001;
      cycle();
      gen_valid = 1'b0;
      cycle();
      check("pre_rst_valid", out_valid, 1'b1);
      check("pre_rst_cnt", err_cnt, CNT_EN ? 2'd2 : 2'd0);
      #2;
      n_rst = 1'b0;
      #1;
      check_reset_values("midrst");
      model_reset();
      idle();
      out_ready = 1'b1;
      @(negedge clk);
      n_rst = 1'b1;
      @(posedge clk);
      #1;

      // random traffic
      for (int i = 0; i < 400; i++) begin
         odd_mode  = 1'($urandom_range(0, 1));
         gen_valid = 1'($urandom_range(0, 1));
         gen_data  = 5'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         chk_valid = 1'($urandom_range(0, 1));
         chk_word  = 6'($urandom);
         err_clr   = ($urandom_range(0, 15) == 0);
         cycle();
      end
      idle();
      cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
